// File: rtl/stream_processing_core.sv
// Multi-lane stream processing core with valid/ready handshaking and a
// stall-capable pipeline of PIPE_STAGES register stages. Stage 0 computes the
// per-lane result (pass, wrapping add, saturating add, invert). Later stages
// only carry it forward. Bubbles collapse, and the ready path is combinational
// from out_ready back to in_ready.
// Optional feature: define STREAM_CORE_STATS_EN to build the beat_count and
// sat_count statistics counters. Without it both outputs are tied to 0.
module stream_processing_core #(
    parameter int unsigned DATWIDTH    = 32,
    parameter int unsigned LANES       = 1,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [1:0]                  mode,
    input  logic [DATWIDTH-1:0]         offset,
    input  logic [LANES*DATWIDTH-1:0]   in_data,
    input  logic                        in_last,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [LANES*DATWIDTH-1:0]   out_data,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES-1:0]            sat_flags,
    output logic [31:0]                 beat_count,
    output logic [31:0]                 sat_count
);

    localparam int unsigned W = LANES * DATWIDTH;

    logic [PIPE_STAGES-1:0]              valid_q, valid_d;
    logic [PIPE_STAGES-1:0][W-1:0]       data_q, data_d;
    logic [PIPE_STAGES-1:0]              last_q, last_d;
    logic [PIPE_STAGES-1:0][LANES-1:0]   sat_q, sat_d;

    logic [PIPE_STAGES-1:0] load;
    logic                   hole;

    logic [DATWIDTH-1:0] lane_x;
    logic [DATWIDTH:0]   lane_sum;
    logic [W-1:0]        s0_data;
    logic [LANES-1:0]    s0_sat;

    // Stage 0 datapath: apply the sampled mode/offset to every lane.
    always_comb begin
        s0_data  = '0;
        s0_sat   = '0;
        lane_x   = '0;
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_x   = in_data[i*DATWIDTH +: DATWIDTH];
            lane_sum = {1'b0, lane_x} + {1'b0, offset};
            unique case (mode)
                2'b00: s0_data[i*DATWIDTH +: DATWIDTH] = lane_x;
                2'b01: s0_data[i*DATWIDTH +: DATWIDTH] = lane_sum[DATWIDTH-1:0];
                2'b10: begin
                    if (lane_sum[DATWIDTH]) begin
                        s0_data[i*DATWIDTH +: DATWIDTH] = '1;
                        s0_sat[i]                       = 1'b1;
                    end else begin
                        s0_data[i*DATWIDTH +: DATWIDTH] = lane_sum[DATWIDTH-1:0];
                    end
                end
                default: s0_data[i*DATWIDTH +: DATWIDTH] = ~lane_x;
            endcase
        end
    end

    // Load enables: a stage may load if it, or any stage after it, frees up this
    // cycle. hole accumulates "some later slot opens" from the output backwards.
    always_comb begin
        load = '0;
        hole = out_ready;
        for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
            load[k] = !valid_q[k] || hole;
            hole    = hole || !valid_q[k];
        end
    end

    assign in_ready = reset_n && load[0];

    // Next-state of the stage chain: each loading stage takes its predecessor.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        sat_d   = sat_q;
        if (load[0]) begin
            valid_d[0] = in_valid;
            data_d[0]  = s0_data;
            last_d[0]  = in_last;
            sat_d[0]   = s0_sat;
        end
        for (int k = 1; k < PIPE_STAGES; k++) begin
            if (load[k]) begin
                valid_d[k] = valid_q[k-1];
                data_d[k]  = data_q[k-1];
                last_d[k]  = last_q[k-1];
                sat_d[k]   = sat_q[k-1];
            end
        end
    end

    // Pipeline registers; reset discards every in-flight beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            data_q  <= '0;
            last_q  <= '0;
            sat_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            sat_q   <= sat_d;
        end
    end

    assign out_valid = valid_q[PIPE_STAGES-1];
    assign out_data  = data_q[PIPE_STAGES-1];
    assign out_last  = last_q[PIPE_STAGES-1];
    assign sat_flags = sat_q[PIPE_STAGES-1];

`ifdef STREAM_CORE_STATS_EN
    logic        out_fire;
    logic [31:0] beat_count_q;
    logic [31:0] sat_count_q;
    logic [31:0] sat_pop;

    assign out_fire = out_valid && out_ready;

    // Number of saturated lanes in the beat currently on the output.
    always_comb begin
        sat_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            sat_pop = sat_pop + {31'b0, sat_flags[i]};
        end
    end

    // Statistics counters advance only on output transfers and wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_count_q <= '0;
            sat_count_q  <= '0;
        end else if (out_fire) begin
            beat_count_q <= beat_count_q + 32'd1;
            sat_count_q  <= sat_count_q + sat_pop;
        end
    end

    assign beat_count = beat_count_q;
    assign sat_count  = sat_count_q;
`else
    assign beat_count = '0;
    assign sat_count  = '0;
`endif

endmodule

// File: tb/tb_stream_processing_core.sv
// Bench for stream_processing_core (DATWIDTH=8, LANES=2, PIPE_STAGES=3).
// A queue-based reference model predicts every output beat from the accepted
// inputs; directed tests add literal expectations for modes, latency and counters.
module tb_stream_processing_core;

    localparam int unsigned DW = 8;
    localparam int unsigned NL = 2;
    localparam int unsigned PS = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [7:0]    offset = 8'h00;
    logic [15:0]   in_data = 16'h0000;
    logic          in_last = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   out_data;
    logic          out_last;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [1:0]    sat_flags;
    logic [31:0]   beat_count;
    logic [31:0]   sat_count;

    stream_processing_core #(
        .DATWIDTH   (DW),
        .LANES      (NL),
        .PIPE_STAGES(PS)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mode      (mode),
        .offset    (offset),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_flags (sat_flags),
        .beat_count(beat_count),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        l;
        logic [1:0]  s;
    } beat_t;

    beat_t expq[$];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_out = 0;

    bit meas = 1'b0;
    int first_acc = -1;
    int first_out = -1;
    int last_out = -1;
    int out_cnt = 0;
    int last_cnt = 0;

    bit    hold_prev = 1'b0;
    beat_t held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: per-lane unsigned arithmetic straight from the mode rules.
    function automatic beat_t model(input logic [15:0] d, input logic l, input logic [1:0] m,
                                    input logic [7:0] o);
        beat_t b;
        int    x;
        int    r;
        b.d = '0;
        b.l = l;
        b.s = '0;
        for (int i = 0; i < 2; i++) begin
            x = (int'(d) >> (8 * i)) & 255;
            case (m)
                2'b00: r = x;
                2'b01: r = (x + int'(o)) % 256;
                2'b10: begin
                    r = x + int'(o);
                    if (r > 255) begin
                        r      = 255;
                        b.s[i] = 1'b1;
                    end
                end
                default: r = 255 - x;
            endcase
            b.d[i*8 +: 8] = r[7:0];
        end
        return b;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: sampled mid-cycle, so values are what the next edge sees.
    always @(negedge clk) begin
        if (!reset_n) begin
            expq.delete();
            hold_prev = 1'b0;
            chk("reset_outputs", {12'b0, out_valid, in_ready, out_last, sat_flags, out_data},
                32'h0);
        end else begin
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk("unexpected_beat", {13'b0, out_data, out_last, sat_flags}, 32'hFFFFFFFF);
                end else begin
                    chk("beat", {13'b0, out_data, out_last, sat_flags},
                        {13'b0, expq[0].d, expq[0].l, expq[0].s});
                end
                if (hold_prev)
                    chk("stall_stable", {13'b0, out_data, out_last, sat_flags},
                        {13'b0, held.d, held.l, held.s});
                if (meas) begin
                    if (first_out < 0) first_out = cyc;
                    last_out = cyc;
                    out_cnt++;
                    if (out_last) last_cnt++;
                end
                if (out_ready) begin
                    if (expq.size() != 0) void'(expq.pop_front());
                    n_out++;
                    hold_prev = 1'b0;
                end else begin
                    hold_prev = 1'b1;
                    held.d    = out_data;
                    held.l    = out_last;
                    held.s    = sat_flags;
                end
            end else begin
                hold_prev = 1'b0;
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(in_data, in_last, mode, offset));
                if (meas && first_acc < 0) first_acc = cyc;
            end
        end
    end

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic [15:0] d, input logic l, input logic [1:0] m,
                        input logic [7:0] o);
        int t;
        in_data  = d;
        in_last  = l;
        mode     = m;
        offset   = o;
        in_valid = 1'b1;
        t = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 100) begin
                chk("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (expq.size() != 0 || out_valid) begin
            @(negedge clk);
            t++;
            if (t > 300) begin
                chk("drain_timeout", expq.size(), 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic mode_check(input string name, input logic [1:0] m, input logic [15:0] exp_d,
                              input logic [1:0] exp_s);
        int t;
        out_ready = 1'b1;
        send(16'h05F0, 1'b0, m, 8'h20);
        t = 0;
        while (!out_valid && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_valid"}, {31'b0, out_valid}, 32'd1);
        chk({name, "_data"}, {16'b0, out_data}, {16'b0, exp_d});
        chk({name, "_sat"}, {30'b0, sat_flags}, {30'b0, exp_s});
        drain();
    endtask

    initial begin
        int n0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk("idle_in_ready", {31'b0, in_ready}, 32'd1);
        chk("idle_beat_count", beat_count, 32'd0);
        @(posedge clk);
        #1;

        // Modes on lanes 0xF0 / 0x05 with offset 0x20.
        mode_check("mode00", 2'b00, 16'h05F0, 2'b00);
        mode_check("mode01", 2'b01, 16'h2510, 2'b00);
        mode_check("mode10", 2'b10, 16'h25FF, 2'b01);
        mode_check("mode11", 2'b11, 16'hFA0F, 2'b00);

        // Latency and throughput: 16 back-to-back beats, last on beat 16.
        out_ready = 1'b1;
        first_acc = -1;
        first_out = -1;
        out_cnt   = 0;
        last_cnt  = 0;
        meas      = 1'b1;
        for (int i = 0; i < 16; i++)
            send(16'(i * 257 + 1), i == 15, 2'b01, 8'h01);
        drain();
        meas = 1'b0;
        chk("latency", first_out - first_acc, 32'd3);
        chk("out_count", out_cnt, 32'd16);
        chk("out_contiguous", last_out - first_out + 1, 32'd16);
        chk("last_count", last_cnt, 32'd1);

        // Back-pressure: out_ready low for 10 cycles while streaming 8 beats.
        n0 = n_out;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(16'(i * 37 + 3), i == 7, 2'(i % 4), 8'h40);
            end
            begin
                repeat (6) @(negedge clk);
                chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
                chk("bp_held_beats", expq.size(), 32'd3);
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_no_loss", n_out - n0, 32'd8);

        // Mode change 01 -> 11 between beats 4 and 5 while beats are in flight.
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(16'h1234 + 16'(i), 1'b0, (i < 4) ? 2'b01 : 2'b11, 8'h10);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with 3 beats in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(16'hA5A5 + 16'(i), 1'b1, 2'b10, 8'hF0);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", {16'b0, out_data}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_flags", {30'b0, out_last, sat_flags[0]}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (10) @(negedge clk);
        chk("post_rst_no_stale", {31'b0, out_valid}, 32'd0);
        chk("post_rst_beat_count", beat_count, 32'd0);
        chk("post_rst_sat_count", sat_count, 32'd0);
        @(posedge clk);
        #1;

        // Statistics: 100 beats with 7 saturated lanes.
        for (int i = 0; i < 100; i++) begin
            if (i < 7) send(16'h05F0, 1'b0, 2'b10, 8'h20);
            else send(16'(i), 1'b0, 2'b00, 8'h00);
        end
        drain();
`ifdef STREAM_CORE_STATS_EN
        chk("stat_beat_count", beat_count, 32'd100);
        chk("stat_sat_count", sat_count, 32'd7);
        @(negedge clk);
        force dut.beat_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.beat_count_q;
        @(posedge clk);
        #1;
        send(16'h0101, 1'b1, 2'b00, 8'h00);
        drain();
        chk("stat_wrap", beat_count, 32'd0);
        chk("stat_sat_hold", sat_count, 32'd7);
`else
        chk("nostat_beat_count", beat_count, 32'd0);
        chk("nostat_sat_count", sat_count, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

endmodule
